// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: command and SRAM port bundle for the word-copy DMA engine.
// The engine is the slave side: it takes commands and drives the shared SRAM port.
// The master side is the controller/top level: it issues commands, drives
// cpu_mem_req and returns SRAM read data.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high only while the engine is
// idle. A cmd_valid asserted while cmd_ready is low is dropped, not held or queued,
// so the controller must re-issue it once cmd_ready returns.
interface dma_copy_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Command channel
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_len;
  logic              cmd_ready;
  logic              abort;

  // Shared SRAM port arbitration and engine-side SRAM drive
  logic              cpu_mem_req;
  logic              dma_grant;
  logic [ADDR_W-1:0] dma_sram_ADDR;
  logic [DATA_W-1:0] dma_sram_DI;
  logic              dma_sram_EN;
  logic              dma_sram_WE;
  logic [DATA_W-1:0] sram_DO;

  // Status
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] remaining;

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, abort, cpu_mem_req, sram_DO,
    output cmd_ready, dma_grant, dma_sram_ADDR, dma_sram_DI, dma_sram_EN,
           dma_sram_WE, busy, done, remaining
  );

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, abort, cpu_mem_req, sram_DO,
    input  cmd_ready, dma_grant, dma_sram_ADDR, dma_sram_DI, dma_sram_EN,
           dma_sram_WE, busy, done, remaining
  );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-copy DMA that borrows idle cycles of the single SRAM port.
// Each word is read (READ), the registered SRAM output is captured (CAPTURE), then
// it is written (WRITE). The CPU always wins the port: whenever cpu_mem_req is high,
// a READ or WRITE waits in place and the engine leaves the port alone.
//
// Optional feature macro: DMA_ABORT_EN. When defined, abort cancels a transfer in
// progress. When undefined, abort is ignored and every transfer runs to the end.
module dma_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  dma_copy_engine_if.slave     bus,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] rem_q;
  logic [DATA_W-1:0] buf_q;

  logic              accept;
  logic              in_xfer;
  logic              grant;
  logic              rd_fire;
  logic              wr_fire;
  logic              last_word;
  logic              abort_req;

  // Decode the control strobes for the current cycle.
  always_comb begin
    accept    = (state == S_IDLE) && bus.cmd_valid;
    in_xfer   = (state == S_READ) || (state == S_CAPTURE) || (state == S_WRITE);
    grant     = ((state == S_READ) || (state == S_WRITE)) && !bus.cpu_mem_req;
    rd_fire   = grant && (state == S_READ);
    wr_fire   = grant && (state == S_WRITE);
    last_word = (rem_q == ADDR_W'(1));
  end

`ifdef DMA_ABORT_EN
  // Abort is honoured only while a transfer is actually moving words.
  always_comb begin
    abort_req = in_xfer && bus.abort;
  end
`else
  logic unused_abort;

  // Abort support is compiled out; the input is deliberately left unused.
  always_comb begin
    abort_req    = 1'b0;
    unused_abort = bus.abort ^ in_xfer;
  end
`endif

  // Next-state logic. A granted write in the same cycle as an abort still lands
  // first, because the datapath update below depends only on wr_fire.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt = (bus.cmd_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (abort_req) begin
          state_nxt = S_DONE;
        end else if (rd_fire) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // No port use here; sram_DO carries our read regardless of the CPU.
        state_nxt = abort_req ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        if (wr_fire) begin
          state_nxt = (last_word || abort_req) ? S_DONE : S_READ;
        end else if (abort_req) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address/count registers: loaded on accept, advanced on each completed write.
  // Address arithmetic wraps naturally at the ADDR_W boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      src_q <= bus.cmd_src;
      dst_q <= bus.cmd_dst;
      rem_q <= bus.cmd_len;
    end else if (wr_fire) begin
      src_q <= src_q + ADDR_W'(1);
      dst_q <= dst_q + ADDR_W'(1);
      rem_q <= rem_q - ADDR_W'(1);
    end
  end

  // Data buffer: holds the word read in the previous READ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
    end else if (state == S_CAPTURE) begin
      buf_q <= bus.sram_DO;
    end
  end

  // SRAM drive: everything is forced to zero whenever the engine is not granted,
  // so the top-level mux never sees stale engine values.
  always_comb begin
    bus.dma_grant     = grant;
    bus.dma_sram_EN   = grant;
    bus.dma_sram_WE   = wr_fire;
    bus.dma_sram_ADDR = '0;
    bus.dma_sram_DI   = '0;
    if (rd_fire) begin
      bus.dma_sram_ADDR = src_q;
    end else if (wr_fire) begin
      bus.dma_sram_ADDR = dst_q;
      bus.dma_sram_DI   = buf_q;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.cmd_ready = (state == S_IDLE);
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.remaining = rem_q;
    state_dbg     = state;
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: table-driven and randomized bench for dma_copy_engine.
// A behavioural SRAM (registered read data, CPU reads at random addresses when the
// CPU owns the port) sits behind the engine. Expected memory images come from a plain
// forward-copy loop, expected bus accesses from an address/data list, and expected
// completion time from walking a read/capture/write phase list against the CPU
// request pattern.
module tb_dma_copy_engine;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXC = 512;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    int            mode;      // 0 no CPU, 1 CPU on odd cycles, 2 on even, 3 random
    bit            inject;    // extra cmd_valid while busy
    int            abort_c;   // cycle to pulse abort (0 = never)
    int            exp_done;  // fixed expected done cycle (0 = use model)
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  dma_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dma_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic          fill_req;
  bit            cpu_pat [0:MAXC];

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= $urandom;
      mem[16'h0100] <= 32'hA000_000A;
      mem[16'h0101] <= 32'hB000_000B;
      mem[16'h0102] <= 32'hC000_000C;
      mem[16'h0103] <= 32'hD000_000D;
    end else if (bus.dma_grant) begin
      if (bus.dma_sram_WE) mem[bus.dma_sram_ADDR] <= bus.dma_sram_DI;
      else bus.sram_DO <= mem[bus.dma_sram_ADDR];
    end else if (bus.cpu_mem_req) begin
      bus.sram_DO <= mem[$urandom_range(65535)];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) n++;
    check(name, n, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_grant"}, bus.dma_grant, 0);
    check({tag, "_en_we"}, {bus.dma_sram_EN, bus.dma_sram_WE}, 0);
    check({tag, "_addr"}, bus.dma_sram_ADDR, 0);
    check({tag, "_di"}, bus.dma_sram_DI, 0);
    check({tag, "_remaining"}, bus.remaining, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_memory();
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
  endtask

  // Leaves the bench 1 time unit into cycle 1 (command accepted at edge 0).
  task automatic start_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW-1:0] len);
    @(negedge clk);
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_copy(input vec_t v);
    int c, p, acc, exp_done;
    bit done_seen;
    logic [AW-1:0] s, d;
    logic [AW+DW:0] e;
    fill_memory();
    for (int k = 1; k <= MAXC; k++) begin
      case (v.mode)
        0:       cpu_pat[k] = 1'b0;
        1:       cpu_pat[k] = (k % 2 == 1);
        2:       cpu_pat[k] = (k % 2 == 0);
        default: cpu_pat[k] = ($urandom_range(99) < 40);
      endcase
    end
    // Reference: ascending forward copy, plus the expected access list.
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      s = v.src + AW'(i);
      d = v.dst + AW'(i);
      ref_mem[d] = ref_mem[s];
      exp_q.push_back({1'b0, s, {DW{1'b0}}});
      exp_q.push_back({1'b1, d, ref_mem[d]});
    end
    // Timing: phases R,C,W per word; R and W wait out CPU cycles, C never does.
    p = 0;
    c = 1;
    while (p < 3 * int'(v.len) && c < MAXC) begin
      if (p % 3 == 1 || !cpu_pat[c]) p++;
      c++;
    end
    exp_done = (v.exp_done > 0) ? v.exp_done : c;

    @(negedge clk);
    check("cmd_ready_before", bus.cmd_ready, 1);
    start_cmd(v.src, v.dst, v.len);
    acc = 0;
    done_seen = 0;
    c = 1;
    while (!done_seen && c <= MAXC) begin
      bus.cpu_mem_req = cpu_pat[c];
      bus.abort       = (c == v.abort_c);
      if (v.inject && (c == 2 || c == 5)) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_src   = AW'($urandom);
        bus.cmd_dst   = AW'($urandom);
        bus.cmd_len   = 16'd3;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      check("grant_with_cpu", bus.dma_grant & bus.cpu_mem_req, 0);
      if (bus.dma_grant) begin
        acc++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("access", {bus.dma_sram_WE, bus.dma_sram_ADDR, bus.dma_sram_DI}, e);
        end else begin
          check("access_overrun", acc, 2 * int'(v.len));
        end
      end else begin
        check("idle_bus", {bus.dma_sram_EN, bus.dma_sram_WE, bus.dma_sram_ADDR,
                           bus.dma_sram_DI}, 0);
      end
      if (c == 1) check("remaining_at_start", bus.remaining, v.len);
      check("busy_ready", {bus.busy, bus.cmd_ready}, 2'b10);
      if (bus.done) begin
        check("done_cycle", c, exp_done);
        check("remaining_at_done", bus.remaining, 0);
        done_seen = 1;
      end else begin
        step();
        c++;
      end
    end
    bus.cmd_valid   = 1'b0;
    bus.abort       = 1'b0;
    bus.cpu_mem_req = 1'b0;
    if (!done_seen) check("done_timeout", c, exp_done);
    step();
    @(negedge clk);
    check("ready_after_done", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
    check("access_count", acc, 2 * int'(v.len));
    check_mem("mem_image");
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[$];
  vec_t rv;

  initial begin
    reset           = 1'b1;
    fill_req        = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_src     = '0;
    bus.cmd_dst     = '0;
    bus.cmd_len     = '0;
    bus.abort       = 1'b0;
    bus.cpu_mem_req = 1'b0;
    step();
    step();
    @(negedge clk);
    check_reset_vals("reset_hold");
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // Directed table: {src, dst, len, cpu mode, inject, abort cycle, done cycle}
    vecs.push_back('{16'h0100, 16'h0200, 16'd4, 0, 1'b0, 0, 13});
    vecs.push_back('{16'h0100, 16'h0200, 16'd4, 1, 1'b0, 0, 17});
    vecs.push_back('{16'h0100, 16'h0200, 16'd4, 2, 1'b0, 0, 16});
    vecs.push_back('{16'h0100, 16'h0200, 16'd0, 0, 1'b0, 0, 1});
    vecs.push_back('{16'hFFFE, 16'h0010, 16'd4, 0, 1'b0, 0, 13});
    vecs.push_back('{16'h0100, 16'h0200, 16'd4, 0, 1'b1, 0, 13});
    vecs.push_back('{16'h0050, 16'h0060, 16'd1, 0, 1'b0, 0, 4});
    vecs.push_back('{16'h0100, 16'h0101, 16'd3, 0, 1'b0, 0, 10});
`ifndef DMA_ABORT_EN
    // Abort is ignored in this build: full copy, normal timing.
    vecs.push_back('{16'h0100, 16'h0200, 16'd4, 0, 1'b0, 5, 13});
`endif
    for (int i = 0; i < vecs.size(); i++) run_copy(vecs[i]);

    // Randomized transfers with random CPU contention and overlapping regions.
    for (int i = 0; i < 8; i++) begin
      rv.src = AW'($urandom);
      case ($urandom_range(2))
        0:       rv.dst = AW'($urandom);
        1:       rv.dst = rv.src + AW'($urandom_range(1, 3));
        default: rv.dst = rv.src - AW'($urandom_range(1, 3));
      endcase
      rv.len      = AW'($urandom_range(1, 10));
      rv.mode     = 3;
      rv.inject   = bit'($urandom_range(1));
      rv.abort_c  = 0;
      rv.exp_done = 0;
      run_copy(rv);
    end

    // Reset in the CAPTURE of word 2: engine stops, no done, only word 1 written.
    fill_memory();
    ref_mem[16'h0400] = ref_mem[16'h0300];
    start_cmd(16'h0300, 16'h0400, 16'd4);
    for (int k = 2; k <= 5; k++) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      check("post_reset_quiet", {bus.done, bus.dma_sram_EN, bus.busy}, 3'b000);
    end
    check_mem("mid_reset_mem");

`ifdef DMA_ABORT_EN
    // Abort in the CAPTURE of word 2: done next cycle with 3 words left.
    fill_memory();
    ref_mem[16'h0200] = ref_mem[16'h0100];
    start_cmd(16'h0100, 16'h0200, 16'd4);
    for (int k = 2; k <= 5; k++) step();
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_capture_no_grant", bus.dma_grant, 0);
    step();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_done", bus.done, 1);
    check("abort_remaining", bus.remaining, 3);
    step();
    @(negedge clk);
    check("abort_ready", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
    check_mem("abort_mem");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-copy DMA engine sharing the single SRAM port with the CPU controller. It consumes copy commands (source, destination, length) issued by the controller and moves words through the SRAM using cycles the CPU leaves idle. The top level selects the engine's SRAM signals whenever `dma_grant` is high; otherwise the CPU owns the port.

## Interface
- `ADDR_W`, default 16: SRAM address width; addresses and length use this width.
- `DATA_W`, default 32: SRAM word width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command strobe from the controller.
- `cmd_src` in ADDR_W: first source word address.
- `cmd_dst` in ADDR_W: first destination word address.
- `cmd_len` in ADDR_W: word count.
- `cmd_ready` out 1: engine is idle and accepts a command.
- `abort` in 1: cancel the transfer in progress (requires `DMA_ABORT_EN`).
- `cpu_mem_req` in 1: the CPU drives the SRAM this cycle, so the engine must not.
- `dma_grant` out 1: the engine drives the SRAM this cycle (top-level mux select).
- `dma_sram_ADDR` out ADDR_W: SRAM address.
- `dma_sram_DI` out DATA_W: SRAM write data.
- `dma_sram_EN` out 1: SRAM enable.
- `dma_sram_WE` out 1: SRAM write enable.
- `sram_DO` in DATA_W: SRAM read data, valid one cycle after the address.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes or aborts.
- `remaining` out ADDR_W: words not yet written.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE. State is registered.
- IDLE:
  - `cmd_ready=1`.
  - `cmd_valid` latches src, dst and len.
  - Goes to DONE if len==0, else to READ.
- READ:
  - If `cpu_mem_req=0`: `dma_grant=1`, EN=1, WE=0, ADDR=src, then go to CAPTURE.
  - Otherwise hold READ with `dma_grant=0`.
- CAPTURE:
  - No SRAM drive; the CPU may use the port.
  - Register `sram_DO` into the data buffer, then go to WRITE.
- WRITE:
  - If `cpu_mem_req=0`: `dma_grant=1`, EN=1, WE=1, ADDR=dst, DI=buffer.
  - On the same edge: src+1, dst+1, remaining-1. Go to DONE if remaining becomes 0, else READ.
  - Otherwise hold WRITE.
- DONE: `done=1` for one cycle, then IDLE.
- `cmd_valid` outside IDLE is ignored and nothing is queued.
- `busy` is 1 in every state except IDLE.
- `dma_grant`, EN and WE are combinational from state and `cpu_mem_req`.
- When `dma_grant=0`: ADDR, DI, EN and WE are all 0.
- Address increments wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
- Copy order is ascending. Overlapping regions get forward-copy semantics, with no hazard correction.
- The CPU always has priority. The engine never blocks the CPU, and its stalls are unbounded.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready=1` from the first cycle after reset.
  - `busy=0`, `done=0`, `dma_grant=0`.
  - ADDR/DI/EN/WE all 0.
  - `remaining=0`, data buffer 0.
- Reset mid-transfer stops immediately. No further SRAM access occurs and no `done` pulse is issued.
- Without contention each word costs 3 cycles: READ, CAPTURE, WRITE.
- With command accepted at edge 0, a length-N transfer issues its last write at cycle 3N and pulses `done` at cycle 3N+1. `cmd_ready` returns at cycle 3N+2.
- len=0: `done` at cycle 1, with no SRAM access.
- Each cycle of `cpu_mem_req=1` in READ or WRITE adds exactly one cycle.
- `cpu_mem_req` in CAPTURE adds no delay, because `sram_DO` still carries the engine's read.

## Configuration
- `DMA_ABORT_EN` defined:
  - `abort=1` in READ, CAPTURE or WRITE goes to DONE on the next edge and pulses `done`.
  - `remaining` holds the count of unwritten words.
  - An already-granted write in the same cycle completes first.
- `DMA_ABORT_EN` undefined: `abort` is ignored and every transfer runs to completion.

## Test plan
- Copy 0x100→0x200, len 4, no contention, memory 0x100..0x103 = A,B,C,D → 0x200..0x203 = A,B,C,D; `done` at cycle 13; exactly 8 granted accesses.
- Same copy with `cpu_mem_req` high every other cycle → the data result is identical; no cycle has both `dma_grant` and `cpu_mem_req` high; completion is delayed by exactly the number of stalled READ/WRITE cycles.
- len=0 → `done` at cycle 1, EN never asserted, `busy` high for one cycle.
- src=0xFFFE, dst=0x0010, len 4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 and writes 0x0010..0x0013.
- Second `cmd_valid` while busy → ignored; the first transfer's result and timing are unchanged.
- With `DMA_ABORT_EN`, abort during the CAPTURE of word 2 of len 4 → `done` next cycle, `remaining=3`, only 0x200 written. Separately, reset mid-transfer → all outputs return to reset values and no `done` pulse occurs.
